// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/exec sequencer for the 16-bit ALU datapath.
// Two-phase ops take an extra EXEC2 cycle; STP and stack faults halt.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [5:0]      opcode,
  output logic [2:0]      rd_sel,
  output logic [2:0]      rs1_sel,
  output logic [2:0]      rs2_sel,
  output logic            alu_enable_n,
  output logic            exec2,
  input  logic            alu_jump,
  input  logic [15:0]     alu_rout,
  output logic            reg_we,
  output logic            mem_we,
  output logic            stack_push,
  output logic            stack_pop,
  input  logic            stack_full,
  input  logic            stack_empty,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  state_t          state;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;
  logic [5:0]      op;
  logic            is_jump;
  logic            is_rd;
  logic            is_two;
  logic            is_psh;
  logic            is_pop;
  logic            is_str;
  logic            is_stp;
  logic            unused;

  assign op         = ir[15:10];
  assign opcode     = op;
  assign rd_sel     = ir[9:7];
  assign rs1_sel    = ir[6:4];
  assign rs2_sel    = ir[3:1];
  assign instr_addr = pc;
  assign unused     = ^{ir[0], alu_rout[15:PC_W]};

  assign is_jump = op inside {6'd0, [6'd4:6'd11]};
  assign is_rd   = op inside {[6'd12:6'd22], [6'd24:6'd26],
                              6'd31, [6'd32:6'd34], 6'd36, 6'd37};
  assign is_two  = op inside {6'd28, 6'd29, 6'd30, 6'd42};
  assign is_psh  = (op == 6'd40);
  assign is_pop  = (op == 6'd41);
  assign is_str  = (op == 6'd43);
  assign is_stp  = (op == 6'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          ir    <= instr_data;
          state <= S_EXEC1;
        end
        S_EXEC1: begin
          unique case (1'b1)
            is_two: state <= S_EXEC2;
            is_jump: begin
              pc    <= alu_jump ? alu_rout[PC_W-1:0] : pc + 1'b1;
              state <= S_FETCH;
            end
            is_psh: begin
              if (stack_full) begin
                fault <= 1'b1;
                state <= S_HALT;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end
            is_pop: begin
              if (stack_empty) begin
                fault <= 1'b1;
                state <= S_HALT;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end
            is_stp: state <= S_HALT;
            default: begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          endcase
        end
        S_EXEC2: begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stack strobes are gated by the flags so a faulting op never touches the stack
  always_comb begin
    alu_enable_n = 1'b1;
    exec2        = 1'b0;
    reg_we       = 1'b0;
    mem_we       = 1'b0;
    stack_push   = 1'b0;
    stack_pop    = 1'b0;
    halted       = 1'b0;
    unique case (state)
      S_EXEC1: begin
        alu_enable_n = 1'b0;
        reg_we       = is_rd | (is_pop & ~stack_empty);
        mem_we       = is_str;
        stack_push   = is_psh & ~stack_full;
        stack_pop    = is_pop & ~stack_empty;
      end
      S_EXEC2: begin
        alu_enable_n = 1'b0;
        exec2        = 1'b1;
        reg_we       = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
